// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine: FSM states, cycle
// constants and the key element bit-position helper.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  localparam int unsigned KSA_DATA_W        = 8;
  localparam int unsigned INIT_CYCLES       = 2 ** KSA_DATA_W;
  localparam int unsigned SWAP_CYCLES_PER_I = 6;

  // Key element 0 lives in the most significant slot of the packed key.
  function automatic int unsigned key_elem_lsb(input int unsigned idx,
                                               input int unsigned key_bytes,
                                               input int unsigned data_w);
    return (key_bytes - 1 - idx) * data_w;
  endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Selects key element (i mod KEY_BYTES) using a wrapping counter that tracks
// i alongside the engine, so no divider is needed.
module ksa_key_sel #(
  parameter int KEY_BYTES = 3,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        advance,
  input  logic [KEY_BYTES*DATA_W-1:0] key_reg,
  output logic [DATA_W-1:0]           key_elem
);
  import rc4_pkg::*;

  localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] elems [KEY_BYTES];

  for (genvar k = 0; k < KEY_BYTES; k++) begin : g_elem
    assign elems[k] = key_reg[key_elem_lsb(k, KEY_BYTES, DATA_W) +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  assign key_elem = elems[idx];

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external single-port synchronous RAM:
// N init writes, then a read/read/write/write swap for every i.
module rc4_ksa_engine #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KEY_BYTES*DATA_W-1:0] key,
  output logic [DATA_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wen,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic                        done
);
  import rc4_pkg::*;

  localparam logic [DATA_W-1:0] LAST_I = '1;

  ksa_state_t                  state;
  logic [DATA_W-1:0]           i;
  logic [DATA_W-1:0]           j;
  logic [DATA_W-1:0]           si;
  logic [DATA_W-1:0]           i_inc;
  logic [DATA_W-1:0]           j_next;
  logic [DATA_W-1:0]           key_elem;
  logic [KEY_BYTES*DATA_W-1:0] key_reg;
  logic                        accept;
  logic                        key_advance;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign key_advance = (state == WR_J) && (i != LAST_I);
  assign i_inc       = i + DATA_W'(1);
  assign j_next      = j + mem_rdata + key_elem;

  ksa_key_sel #(
    .KEY_BYTES (KEY_BYTES),
    .DATA_W    (DATA_W)
  ) u_key_sel (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .advance  (key_advance),
    .key_reg  (key_reg),
    .key_elem (key_elem)
  );

  // Outputs are loaded on entry to a state, so the address a state needs is
  // on the bus during that state and read data arrives in the following one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      key_reg   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_reg   <= key;
            i         <= '0;
            j         <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          if (i == LAST_I) begin
            i        <= '0;
            mem_addr <= '0;
            mem_wen  <= 1'b0;
            state    <= RD_I;
          end else begin
            i         <= i_inc;
            mem_addr  <= i_inc;
            mem_wdata <= i_inc;
          end
        end
        RD_I: state <= GET_I;
        GET_I: begin
          si       <= mem_rdata;
          j        <= j_next;
          mem_addr <= j_next;
          state    <= RD_J;
        end
        RD_J: state <= GET_J;
        // S[j] goes straight into the write-data register for WR_I.
        GET_J: begin
          mem_addr  <= i;
          mem_wdata <= mem_rdata;
          mem_wen   <= 1'b1;
          state     <= WR_I;
        end
        WR_I: begin
          mem_addr  <= j;
          mem_wdata <= si;
          state     <= WR_J;
        end
        WR_J: begin
          mem_wen <= 1'b0;
          if (i == LAST_I) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i        <= i_inc;
            mem_addr <= i_inc;
            state    <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench: two engine configurations against behavioural RAMs and
// a plain-arithmetic RC4 key-schedule model.
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [23:0] key_a;
  logic [2:0]  key_b;
  logic [7:0]  addr_a, wdata_a, rdata_a;
  logic [2:0]  addr_b, wdata_b, rdata_b;
  logic        wen_a, busy_a, done_a;
  logic        wen_b, busy_b, done_b;

  logic [7:0]  mem_a [256];
  logic [2:0]  mem_b [8];
  logic [7:0]  snap_a [256];
  int          wlog_addr[$];
  int          wlog_data[$];
  bit          log_en = 1'b0;
  int          wen_idle_a = 0;

  int          exp_s [256];
  int          exp_wa[$];
  int          exp_wd[$];
  int          checks = 0;
  int          failures = 0;

  rc4_ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key(key_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wen(wen_a),
    .mem_rdata(rdata_a), .busy(busy_a), .done(done_a)
  );

  rc4_ksa_engine #(.DATA_W(3), .KEY_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key(key_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wen(wen_b),
    .mem_rdata(rdata_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural single-port RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (wen_a) begin
      mem_a[addr_a] <= wdata_a;
      if (log_en) begin
        wlog_addr.push_back(int'(addr_a));
        wlog_data.push_back(int'(wdata_a));
      end
    end
    if (wen_a && !busy_a) wen_idle_a <= wen_idle_a + 1;
    rdata_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (wen_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  // Reference key schedule, also listing every RAM write in issue order.
  task automatic model_ksa(input int w, input int kb, input logic [31:0] k);
    int n;
    int jj;
    int ke;
    int t;
    n = 1 << w;
    jj = 0;
    exp_wa.delete();
    exp_wd.delete();
    for (int x = 0; x < n; x++) begin
      exp_s[x] = x;
      exp_wa.push_back(x);
      exp_wd.push_back(x);
    end
    for (int x = 0; x < n; x++) begin
      ke = int'((k >> ((kb - 1 - (x % kb)) * w)) & 32'(n - 1));
      jj = (jj + exp_s[x] + ke) % n;
      exp_wa.push_back(x);
      exp_wd.push_back(exp_s[jj]);
      exp_wa.push_back(jj);
      exp_wd.push_back(exp_s[x]);
      t = exp_s[x];
      exp_s[x] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  // Starts a schedule at a negedge and counts busy cycles until busy falls.
  task automatic run_sched(input bit sel_b, input logic [23:0] k, input int hold,
                           input bit noise, output int cyc, output bit first_busy,
                           output bit first_done, output bit tout);
    if (sel_b) begin
      key_b = k[2:0];
      start_b = 1'b1;
    end else begin
      key_a = k;
      start_a = 1'b1;
    end
    cyc = 0;
    tout = 1'b1;
    first_busy = 1'b0;
    first_done = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        first_busy = sel_b ? busy_b : busy_a;
        first_done = sel_b ? done_b : done_a;
      end
      if (c + 1 >= hold) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (noise && (c + 1 >= hold) && (c < 1600)) begin
        start_a = 1'($urandom_range(0, 1));
        key_a = 24'($urandom);
      end
      if ((sel_b ? busy_b : busy_a) === 1'b1) cyc++;
      else begin
        tout = 1'b0;
        break;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bit fb, fd, tout;
    int bad;
    int first;
    logic [23:0] k;
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    key_a = '0;
    key_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr_a, wdata_a, wen_a, busy_a, done_a} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_state_a: got %h expected 0", {addr_a, wdata_a, wen_a, busy_a, done_a});
    end
    checks++;
    if ({addr_b, wdata_b, wen_b, busy_b, done_b} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_state_b: got %h expected 0", {addr_b, wdata_b, wen_b, busy_b, done_b});
    end
    reset = 1'b0;
    @(negedge clk);
    key_a = 24'($urandom);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({busy_a, wen_a} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL mid_init_active: got busy/wen=%b expected 11", {busy_a, wen_a});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({addr_a, wdata_a, wen_a, busy_a, done_a} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_clear: got %h expected 0", {addr_a, wdata_a, wen_a, busy_a, done_a});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    k = 24'($urandom);
    model_ksa(8, 3, 32'(k));
    run_sched(1'b0, k, 1, 1'b0, cyc, fb, fd, tout);
    checks++;
    if (tout || cyc !== 1792) begin
      failures++;
      $display("[TB] FAIL post_reset_busy_len: got %0d (timeout=%0b) expected 1792", cyc, tout);
    end
    bad = 0;
    first = -1;
    for (int x = 0; x < 256; x++)
      if (mem_a[x] !== 8'(exp_s[x])) begin
        bad++;
        if (first < 0) first = x;
      end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_sbox: %0d entries differ, first at %0d got %0d expected %0d",
               bad, first, mem_a[first], exp_s[first]);
    end
  endtask

  task automatic test_init_and_self_swap();
    int cyc;
    bit fb, fd, tout;
    int bad;
    int spot_a[6];
    int spot_d[6];
    spot_a = '{0, 0, 1, 1, 2, 3};
    spot_d = '{0, 0, 1, 1, 3, 2};
    model_ksa(8, 3, 32'h0);
    wlog_addr.delete();
    wlog_data.delete();
    log_en = 1'b1;
    run_sched(1'b0, 24'h000000, 1, 1'b0, cyc, fb, fd, tout);
    log_en = 1'b0;
    checks++;
    if (wlog_addr.size() !== 768) begin
      failures++;
      $display("[TB] FAIL write_count: got %0d expected 768", wlog_addr.size());
    end
    if (wlog_addr.size() >= 768) begin
      bad = 0;
      for (int x = 0; x < 256; x++)
        if (wlog_addr[x] !== x || wlog_data[x] !== x) bad++;
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("[TB] FAIL init_writes: %0d of 256 writes wrong, expected addr k data k", bad);
      end
      for (int m = 0; m < 6; m++) begin
        checks++;
        if (wlog_addr[256 + m] !== spot_a[m] || wlog_data[256 + m] !== spot_d[m]) begin
          failures++;
          $display("[TB] FAIL early_swap_write%0d: got mem[%0d]<=%0d expected mem[%0d]<=%0d",
                   m, wlog_addr[256 + m], wlog_data[256 + m], spot_a[m], spot_d[m]);
        end
      end
      bad = 0;
      for (int m = 0; m < 768; m++)
        if (wlog_addr[m] !== exp_wa[m] || wlog_data[m] !== exp_wd[m]) bad++;
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("[TB] FAIL write_sequence: %0d of 768 writes differ from model", bad);
      end
    end
  endtask

  task automatic test_random_key();
    int cyc;
    bit fb, fd, tout;
    int bad;
    int idle_bad;
    logic [23:0] k;
    k = 24'($urandom);
    model_ksa(8, 3, 32'(k));
    run_sched(1'b0, k, 1, 1'b0, cyc, fb, fd, tout);
    checks++;
    if (tout || cyc !== 1792) begin
      failures++;
      $display("[TB] FAIL busy_length: got %0d (timeout=%0b) expected 1792", cyc, tout);
    end
    checks++;
    if ({fb, fd} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL first_cycle_flags: got busy/done=%b expected 10", {fb, fd});
    end
    checks++;
    if (done_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL done_with_busy_fall: got done=%b expected 1", done_a);
    end
    idle_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wen_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b1) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin
      failures++;
      $display("[TB] FAIL quiet_after_done: %0d cycles with activity, expected 0", idle_bad);
    end
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (mem_a[x] !== 8'(exp_s[x])) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL sbox_random_key: %0d entries differ from model, expected 0", bad);
    end
  endtask

  task automatic test_small_config();
    int cyc;
    bit fb, fd, tout;
    int want[8];
    int bad;
    logic [23:0] k;
    want = '{0, 2, 3, 4, 5, 6, 7, 1};
    run_sched(1'b1, 24'h1, 1, 1'b0, cyc, fb, fd, tout);
    checks++;
    if (tout || cyc !== 56) begin
      failures++;
      $display("[TB] FAIL small_busy_length: got %0d (timeout=%0b) expected 56", cyc, tout);
    end
    for (int x = 0; x < 8; x++) begin
      checks++;
      if (mem_b[x] !== 3'(want[x])) begin
        failures++;
        $display("[TB] FAIL small_sbox[%0d]: got %0d expected %0d", x, mem_b[x], want[x]);
      end
    end
    k = 24'($urandom_range(0, 7));
    model_ksa(3, 1, 32'(k));
    run_sched(1'b1, k, 1, 1'b0, cyc, fb, fd, tout);
    bad = 0;
    for (int x = 0; x < 8; x++)
      if (mem_b[x] !== 3'(exp_s[x])) bad++;
    checks++;
    if (tout || bad !== 0) begin
      failures++;
      $display("[TB] FAIL small_random_key %0d: %0d entries differ (timeout=%0b), expected 0", k, bad, tout);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit fb, fd, tout;
    int bad;
    logic [23:0] k;
    k = 24'($urandom);
    model_ksa(8, 3, 32'(k));
    run_sched(1'b0, k, 3, 1'b1, cyc, fb, fd, tout);
    checks++;
    if (tout || cyc !== 1792) begin
      failures++;
      $display("[TB] FAIL noisy_busy_length: got %0d (timeout=%0b) expected 1792", cyc, tout);
    end
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (mem_a[x] !== 8'(exp_s[x])) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL noisy_sbox: %0d entries differ from original-key model, expected 0", bad);
    end
  endtask

  task automatic test_restart();
    int cyc;
    bit fb, fd, tout;
    int bad;
    logic [23:0] k;
    k = 24'($urandom);
    model_ksa(8, 3, 32'(k));
    run_sched(1'b0, k, 5, 1'b0, cyc, fb, fd, tout);
    checks++;
    if ({fb, fd} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL restart_flags: got busy/done=%b expected 10", {fb, fd});
    end
    checks++;
    if (tout || cyc !== 1792) begin
      failures++;
      $display("[TB] FAIL restart_busy_length: got %0d (timeout=%0b) expected 1792", cyc, tout);
    end
    for (int x = 0; x < 256; x++) snap_a[x] = mem_a[x];
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (snap_a[x] !== 8'(exp_s[x])) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL restart_sbox: %0d entries differ from model, expected 0", bad);
    end
    run_sched(1'b0, k, 5, 1'b0, cyc, fb, fd, tout);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (mem_a[x] !== snap_a[x]) bad++;
    checks++;
    if (tout || bad !== 0) begin
      failures++;
      $display("[TB] FAIL repeat_sbox: %0d entries differ between runs (timeout=%0b), expected 0", bad, tout);
    end
  endtask

  task automatic test_wen_idle();
    checks++;
    if (wen_idle_a !== 0) begin
      failures++;
      $display("[TB] FAIL wen_outside_busy: got %0d cycles expected 0", wen_idle_a);
    end
  endtask

  initial begin
    $display("[TB] starting rc4_ksa_engine bench");
    test_reset();
    test_init_and_self_swap();
    test_random_key();
    test_small_config();
    test_ignore_start();
    test_restart();
    test_wen_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
